cbus_sram_responder: RTL and testbench

- CBus responder (slave) modelling on-chip SRAM behind the arbiter's output request/response pair.
- Accepts single and burst reads/writes from the CBus initiator side (arbiter `oreq`/`oresp`).
- Lets the full core + cache + arbiter path run standalone in simulation and FPGA builds, with no external memory controller.
- Sits where the external CBus memory would normally attach.

---
 rtl/cbus_pkg.sv | 20 ++
 rtl/cbus_sram_responder.sv | 83 ++++++++
 tb/tb_cbus_sram_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cbus_pkg.sv
// cbus_pkg: CBus request/response types shared by initiators and responders
package cbus_pkg;
  typedef enum logic [3:0] {MLEN1 = 4'd0, MLEN2 = 4'd1, MLEN4 = 4'd3, MLEN8 = 4'd7, MLEN16 = 4'd15} cbus_len_e;
  typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP} cbus_burst_e;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    cbus_len_e   len;
    cbus_burst_e burst;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

// File: rtl/cbus_sram_responder.sv
// cbus_sram_responder: on-chip SRAM CBus responder with single/burst access.
// Define CBUS_SRAM_RAND_STALL_EN to add LFSR-driven ready stalls in BEAT.
module cbus_sram_responder import cbus_pkg::*; #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_e;
  state_e      state, state_n;
  logic        is_wr, in_range, stall, hs, we, unused;
  logic [63:0] addr, addr_n, off, wmask;
  logic [3:0]  beat_cnt, lat_cnt;
  logic [AW-1:0] idx;
  cbus_len_e   len;
  cbus_burst_e burst;
  logic [63:0] mem [MEM_WORDS] = '{default: '0};
  assign unused   = ^creq.size;
  assign off      = addr - BASE_ADDR;
  assign in_range = addr >= BASE_ADDR && off < (64'(MEM_WORDS) << 3);
  assign idx      = off[AW+2:3];
  assign wmask    = {57'd0, len, 3'b111};
  // INCR keeps the bits above the array so the word index wraps in place
  always_comb
    addr_n = burst == BURST_FIXED ? addr :
             burst == BURST_WRAP  ? (addr & ~wmask) | ((addr + 64'd8) & wmask) :
             {addr[63:AW+3], addr[AW+2:0] + (AW+3)'(8)};
`ifdef CBUS_SRAM_RAND_STALL_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk)
    lfsr <= reset ? 8'hA5 : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif
  always_comb begin
    cresp.ready = state == BEAT && creq.valid && !stall;
    cresp.last  = cresp.ready && beat_cnt == len;
    cresp.data  = state == BEAT && in_range ? mem[idx] : 64'd0;
  end
  assign hs = cresp.ready;
  assign we = hs && is_wr && in_range && !reset;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = creq.valid ? (LATENCY == 0 ? BEAT : WAIT) : IDLE;
      WAIT:    state_n = !creq.valid ? IDLE : lat_cnt == 4'd1 ? BEAT : WAIT;
      BEAT:    state_n = !creq.valid || cresp.last ? IDLE : BEAT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      lat_cnt  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && creq.valid) begin
        is_wr    <= creq.is_write;
        addr     <= creq.addr;
        len      <= creq.len;
        burst    <= creq.burst;
        beat_cnt <= '0;
        lat_cnt  <= 4'(LATENCY);
      end
      if (state == WAIT) lat_cnt <= lat_cnt - 4'd1;
      if (hs) begin
        beat_cnt <= beat_cnt + 4'd1;
        addr     <= addr_n;
      end
    end
  end
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < 8; i++)
        if (creq.strobe[i]) mem[idx][8*i +: 8] <= creq.data[8*i +: 8];
endmodule

// File: tb/tb_cbus_sram_responder.sv
// tb_cbus_sram_responder: directed self-checking bench for the CBus SRAM responder
module tb_cbus_sram_responder;
  import cbus_pkg::*;
  localparam int LAT = 2;
  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  int n_assert = 0;
  int n_fail = 0;
  logic [63:0] wd [16];
  logic [63:0] rd [16];

  cbus_sram_responder #(.MEM_WORDS(4096), .BASE_ADDR(64'h8000_0000), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .creq(creq), .cresp(cresp));

  always #5 clk = ~clk;

`ifdef CBUS_SRAM_RAND_STALL_EN
  logic [7:0] m;
  always @(posedge clk) m <= reset ? 8'hA5 : {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drives one transaction; leaves valid high so the next call is back-to-back
  task automatic xfer(input logic wr, input logic [63:0] a, input cbus_len_e len,
                      input cbus_burst_e bt, input logic [7:0] strb, input int abort_at);
    int n = int'(len) + 1;
    int t = 0;
    int b = 0;
    creq.valid = 1'b1; creq.is_write = wr; creq.addr = a; creq.len = len;
    creq.burst = bt; creq.strobe = strb; creq.size = 3'd3;
    while (b < n) begin
      creq.data = wd[b];
      if (b == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; creq.valid = 1'b0;
        #1 check("rst_ready", 64'(cresp.ready), 64'd0);
        return;
      end
      #1;
`ifdef CBUS_SRAM_RAND_STALL_EN
      if (t >= LAT + 1) check("stall_ready", 64'(cresp.ready), 64'(!m[0]));
`else
      if (b == 0 && cresp.ready) check("first_ready", 64'(t), 64'(LAT + 1));
`endif
      if (cresp.ready) begin
        rd[b] = cresp.data;
        check("last", 64'(cresp.last), 64'(b == n - 1));
        b++;
      end
      if (t > 100) begin
        check("hang", 64'(b), 64'(n));
        creq.valid = 1'b0;
        return;
      end
      @(negedge clk);
      t++;
    end
    #1 check("no_double", 64'(cresp.ready), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    creq = '0;
    for (int i = 0; i < 16; i++) wd[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", 64'(cresp.ready), 64'd0);
    check("rst_last", 64'(cresp.last), 64'd0);
    check("rst_data", cresp.data, 64'd0);
    // single write with low-lane strobe, then read back
    wd[0] = 64'h1122_3344_5566_7788;
    xfer(1'b1, 64'h8000_0010, MLEN1, BURST_INCR, 8'h0F, -1);
    xfer(1'b0, 64'h8000_0010, MLEN1, BURST_INCR, 8'h00, -1);
    check("single_rd", rd[0], 64'h0000_0000_5566_7788);
    // 16-beat INCR
    for (int i = 0; i < 16; i++) wd[i] = 64'(i);
    xfer(1'b1, 64'h8000_0100, MLEN16, BURST_INCR, 8'hFF, -1);
    xfer(1'b0, 64'h8000_0100, MLEN16, BURST_INCR, 8'h00, -1);
    for (int i = 0; i < 16; i++) check("incr_rd", rd[i], 64'(i));
    // WRAP over a 64-byte window
    for (int i = 0; i < 8; i++) wd[i] = 64'(i);
    xfer(1'b1, 64'h8000_0200, MLEN8, BURST_INCR, 8'hFF, -1);
    xfer(1'b0, 64'h8000_0220, MLEN8, BURST_WRAP, 8'h00, -1);
    for (int i = 0; i < 8; i++) check("wrap_rd", rd[i], 64'((i + 4) % 8));
    // INCR across the top of the array wraps to word 0
    wd[0] = 64'hA0A0_0000_0000_0FFF; wd[1] = 64'hB0B0_0000_0000_0000;
    xfer(1'b1, 64'h8000_7FF8, MLEN2, BURST_INCR, 8'hFF, -1);
    // below-base read, then valid read back-to-back
    xfer(1'b0, 64'h7FFF_FFF8, MLEN1, BURST_INCR, 8'h00, -1);
    check("oor_rd", rd[0], 64'd0);
    xfer(1'b0, 64'h8000_0010, MLEN1, BURST_INCR, 8'h00, -1);
    check("b2b_rd", rd[0], 64'h0000_0000_5566_7788);
    // write one past the end is dropped
    wd[0] = 64'hDEAD_BEEF_DEAD_BEEF;
    xfer(1'b1, 64'h8000_8000, MLEN1, BURST_INCR, 8'hFF, -1);
    xfer(1'b0, 64'h8000_8000, MLEN1, BURST_INCR, 8'h00, -1);
    check("oor_end_rd", rd[0], 64'd0);
    xfer(1'b0, 64'h8000_7FF8, MLEN2, BURST_INCR, 8'h00, -1);
    check("top_word", rd[0], 64'hA0A0_0000_0000_0FFF);
    check("wrap_word0", rd[1], 64'hB0B0_0000_0000_0000);
    // FIXED burst hits one word only
    for (int i = 0; i < 4; i++) wd[i] = 64'(10 + i);
    xfer(1'b1, 64'h8000_0300, MLEN4, BURST_FIXED, 8'hFF, -1);
    xfer(1'b0, 64'h8000_0300, MLEN2, BURST_INCR, 8'h00, -1);
    check("fixed_rd", rd[0], 64'd13);
    check("fixed_next", rd[1], 64'd0);
    // reset in the cycle of beat 3
    for (int i = 0; i < 8; i++) wd[i] = 64'hAAAA_0000 + 64'(i);
    xfer(1'b1, 64'h8000_0400, MLEN8, BURST_INCR, 8'hFF, -1);
    for (int i = 0; i < 8; i++) wd[i] = 64'h5555_0000 + 64'(i);
    xfer(1'b1, 64'h8000_0400, MLEN8, BURST_INCR, 8'hFF, 3);
    @(negedge clk);
    xfer(1'b0, 64'h8000_0400, MLEN8, BURST_INCR, 8'h00, -1);
    for (int i = 0; i < 8; i++)
      check("rst_keep", rd[i], i < 3 ? 64'h5555_0000 + 64'(i) : 64'hAAAA_0000 + 64'(i));
    creq.valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
